screen_ctrl: RTL and testbench

Screen-mode sequencer for the 1024x768 @ 65 MHz display pipeline. It turns debounced player buttons and the game-over event into the `screen_single` / `screen_multi` selects consumed by the background drawer, plus a `game_run` enable for the gameplay logic. It walks the game through idle, countdown, play and game-over phases. Every visible mode change is applied only at the start of vertical blanking, so a frame is never drawn with two backgrounds.

---
 rtl/screen_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_screen_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/screen_ctrl.sv
// Screen-mode sequencer: idle -> countdown -> play -> game-over, switched only at vblank start.
// Define SCREEN_CTRL_MULTI_EN to enable the multi-player mode; otherwise only SINGLE exists.
module screen_ctrl #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int OVER_FRAMES      = 120,
  localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > OVER_FRAMES) ? COUNTDOWN_FRAMES : OVER_FRAMES,
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1)
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic             vblnk,
  input  logic             btn_single,
  input  logic             btn_multi,
  input  logic             btn_back,
  input  logic             game_over,
  output logic             screen_idle,
  output logic             screen_single,
  output logic             screen_multi,
  output logic             game_run,
  output logic             countdown,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SCREEN_CTRL_MULTI_EN
  localparam logic MULTI_EN = 1'b1;
`else
  localparam logic MULTI_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] COUNT_LOAD  = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0] OVER_LOAD   = CNT_W'(OVER_FRAMES);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_vld_q, req_vld_d;
  logic             req_multi_q, req_multi_d;
  logic             go_q, go_d;
  logic             abort_q, abort_d;
  logic             vblnk_q, btn_single_q, btn_multi_q, btn_back_q;

  logic             frame_tick_s;
  logic             single_edge_s, multi_edge_s, back_edge_s;
  logic             req_vld_eff_s, req_multi_eff_s, go_eff_s, abort_eff_s;

  assign frame_tick_s  = vblnk & ~vblnk_q;
  assign single_edge_s = btn_single & ~btn_single_q;
  assign multi_edge_s  = btn_multi & ~btn_multi_q & MULTI_EN;
  assign back_edge_s   = btn_back & ~btn_back_q;

  // Pending flags including this cycle's events, so an event on the tick cycle still counts.
  always_comb begin
    req_vld_eff_s   = req_vld_q;
    req_multi_eff_s = req_multi_q;
    abort_eff_s     = abort_q;
    go_eff_s        = go_q;
    if (state_q == ST_IDLE) begin
      if (single_edge_s) begin
        req_vld_eff_s   = 1'b1;
        req_multi_eff_s = 1'b0;
      end else if (multi_edge_s) begin
        req_vld_eff_s   = 1'b1;
        req_multi_eff_s = 1'b1;
      end else if (back_edge_s) begin
        req_vld_eff_s   = 1'b0;
        req_multi_eff_s = 1'b0;
      end else begin
        req_vld_eff_s   = req_vld_q;
        req_multi_eff_s = req_multi_q;
      end
    end else begin
      abort_eff_s = abort_q | back_edge_s;
    end
    if ((state_q == ST_PLAY) && game_over) begin
      go_eff_s = 1'b1;
    end else begin
      go_eff_s = go_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    req_vld_d   = req_vld_eff_s;
    req_multi_d = req_multi_eff_s;
    go_d        = go_eff_s;
    abort_d     = abort_eff_s;
    if (frame_tick_s) begin
      // Every tick consumes whatever was pending; nothing carries over to the next frame.
      req_vld_d   = 1'b0;
      req_multi_d = 1'b0;
      go_d        = 1'b0;
      abort_d     = 1'b0;
      if (abort_eff_s) begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req_vld_eff_s) begin
              state_d = ST_COUNT;
              mode_d  = req_multi_eff_s & MULTI_EN;
              cnt_d   = COUNT_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_COUNT: begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_PLAY;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_PLAY: begin
            if (go_eff_s) begin
              state_d = ST_OVER;
              cnt_d   = OVER_LOAD;
            end else begin
              state_d = ST_PLAY;
            end
          end
          ST_OVER: begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      cnt_q         <= CNT_ZERO;
      req_vld_q     <= 1'b0;
      req_multi_q   <= 1'b0;
      go_q          <= 1'b0;
      abort_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      btn_single_q  <= 1'b0;
      btn_multi_q   <= 1'b0;
      btn_back_q    <= 1'b0;
      screen_idle   <= 1'b1;
      screen_single <= 1'b0;
      screen_multi  <= 1'b0;
      game_run      <= 1'b0;
      countdown     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d & MULTI_EN;
      cnt_q         <= cnt_d;
      req_vld_q     <= req_vld_d;
      req_multi_q   <= req_multi_d & MULTI_EN;
      go_q          <= go_d;
      abort_q       <= abort_d;
      vblnk_q       <= vblnk;
      btn_single_q  <= btn_single;
      btn_multi_q   <= btn_multi;
      btn_back_q    <= btn_back;
      // Outputs decode the next state so they switch on the same edge as the state itself.
      screen_idle   <= (state_d == ST_IDLE);
      screen_single <= (state_d != ST_IDLE) & ~(mode_d & MULTI_EN);
      screen_multi  <= (state_d != ST_IDLE) & mode_d & MULTI_EN;
      game_run      <= (state_d == ST_PLAY);
      countdown     <= (state_d == ST_COUNT);
    end
  end

  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed self-checking bench for screen_ctrl with COUNTDOWN_FRAMES=3, OVER_FRAMES=2.
module tb_screen_ctrl;
  localparam int CD = 3;
  localparam int OV = 2;

  logic       clk65MHz = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       btn_single = 1'b0;
  logic       btn_multi = 1'b0;
  logic       btn_back = 1'b0;
  logic       game_over = 1'b0;
  logic       screen_idle, screen_single, screen_multi, game_run, countdown;
  logic [1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk65MHz = ~clk65MHz;

  screen_ctrl #(.COUNTDOWN_FRAMES(CD), .OVER_FRAMES(OV)) dut (
    .clk65MHz      (clk65MHz),
    .rst           (rst),
    .vblnk         (vblnk),
    .btn_single    (btn_single),
    .btn_multi     (btn_multi),
    .btn_back      (btn_back),
    .game_over     (game_over),
    .screen_idle   (screen_idle),
    .screen_single (screen_single),
    .screen_multi  (screen_multi),
    .game_run      (game_run),
    .countdown     (countdown),
    .frame_cnt     (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int idle, input int sgl, input int mlt,
                           input int run, input int cdn, input int cnt);
    chk({tag, ".idle"}, 32'(screen_idle), 32'(idle));
    chk({tag, ".single"}, 32'(screen_single), 32'(sgl));
    chk({tag, ".multi"}, 32'(screen_multi), 32'(mlt));
    chk({tag, ".run"}, 32'(game_run), 32'(run));
    chk({tag, ".countdown"}, 32'(countdown), 32'(cdn));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(cnt));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk65MHz);
    #1;
  endtask

  // One vblank: rise, hold a few lines, fall, some active video.
  task automatic tick();
    vblnk = 1'b1;
    cyc(3);
    vblnk = 1'b0;
    cyc(3);
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_single = 1'b1;
      1: btn_multi  = 1'b1;
      default: btn_back = 1'b1;
    endcase
    cyc(2);
    btn_single = 1'b0;
    btn_multi  = 1'b0;
    btn_back   = 1'b0;
    cyc(2);
  endtask

  task automatic go_play();
    press(0);
    repeat (CD + 1) tick();
  endtask

  initial begin
    cyc(3);
    chk_state("reset", 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2);

    // Single-player start and countdown
    press(0);
    chk_state("no_tick", 1, 0, 0, 0, 0, 0);
    vblnk = 1'b1;
    chk("pre_edge.idle", 32'(screen_idle), 32'd1);
    cyc(1);
    chk_state("cd3", 0, 1, 0, 0, 1, 3);
    cyc(2);
    vblnk = 1'b0;
    cyc(3);
    tick();
    chk_state("cd2", 0, 1, 0, 0, 1, 2);
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    cyc(1);
    tick();
    chk_state("cd1", 0, 1, 0, 0, 1, 1);
    tick();
    chk_state("play", 0, 1, 0, 1, 0, 0);
    tick();
    chk_state("play_hold", 0, 1, 0, 1, 0, 0);

    // Game over sequence
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    cyc(3);
    chk_state("play_wait", 0, 1, 0, 1, 0, 0);
    tick();
    chk_state("over2", 0, 1, 0, 0, 0, 2);
    tick();
    chk_state("over1", 0, 1, 0, 0, 0, 1);
    tick();
    chk_state("over_done", 1, 0, 0, 0, 0, 0);

    // Simultaneous requests, then abort on the last countdown frame
    btn_single = 1'b1;
    btn_multi  = 1'b1;
    cyc(2);
    btn_single = 1'b0;
    btn_multi  = 1'b0;
    cyc(2);
    tick();
    chk_state("simul", 0, 1, 0, 0, 1, 3);
    tick();
    tick();
    chk("simul.cnt1", 32'(frame_cnt), 32'd1);
    press(2);
    tick();
    chk_state("abort_cd", 1, 0, 0, 0, 0, 0);
    tick();
    chk_state("abort_cd_hold", 1, 0, 0, 0, 0, 0);

    // Back in IDLE cancels a pending request
    press(0);
    press(2);
    tick();
    chk_state("back_idle", 1, 0, 0, 0, 0, 0);

`ifdef SCREEN_CTRL_MULTI_EN
    press(1);
    tick();
    chk_state("multi", 0, 0, 1, 0, 1, 3);
    press(0);
    press(2);
    tick();
    chk_state("multi_abort", 1, 0, 0, 0, 0, 0);
    press(0);
    press(1);
    tick();
    chk_state("overwrite", 0, 0, 1, 0, 1, 3);
    press(2);
    tick();
    chk_state("overwrite_abort", 1, 0, 0, 0, 0, 0);
`else
    press(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state("multi_off", 1, 0, 0, 0, 0, 0);
    end
`endif

    // Abort and game_over landing on the same tick as the vblank rise
    go_play();
    chk_state("play2", 0, 1, 0, 1, 0, 0);
    vblnk     = 1'b1;
    game_over = 1'b1;
    btn_back  = 1'b1;
    cyc(1);
    game_over = 1'b0;
    chk_state("collide", 1, 0, 0, 0, 0, 0);
    cyc(2);
    vblnk    = 1'b0;
    btn_back = 1'b0;
    cyc(3);

    // game_over on the tick cycle itself still counts
    go_play();
    vblnk     = 1'b1;
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    chk_state("go_same_tick", 0, 1, 0, 0, 0, 2);
    cyc(2);
    vblnk = 1'b0;
    cyc(3);
    press(2);
    tick();
    chk_state("over_abort", 1, 0, 0, 0, 0, 0);

    // Reset mid-play takes effect without a vblank
    go_play();
    cyc(5);
    rst = 1'b1;
    cyc(1);
    chk_state("rst_mid", 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2);
    tick();
    chk_state("rst_after", 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
